// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
// Shared definitions for the equalizer datapath and its coefficient
// controller: per-band coefficient count, coefficient-store size helper,
// ceil(log2) helper and the controller state encoding.
// ---------------------------------------------------------------------------
package eq_pkg;

    // a0, a1, a2, b1, b2
    localparam int NR_EQ_BAND_COEFF = 5;

    // Total coefficient words for a given channel/band configuration.
    function automatic int nr_eq_coeff(input int nr_channels, input int nr_bands);
        return nr_channels * nr_bands * NR_EQ_BAND_COEFF;
    endfunction

    // Smallest r with 2**r >= value; never less than 1 so ports stay legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // host may write the shadow bank
        ST_PEND = 2'd1,   // commit seen, waiting for a sample boundary
        ST_COPY = 2'd2    // copying the new active bank back into the shadow
    } cf_state_t;

endpackage

// File: rtl/eq_coeff_ram.sv
// ---------------------------------------------------------------------------
// eq_coeff_ram
// One coefficient bank: simple dual-port RAM, one write port and one
// registered read port, written so that a block RAM is inferred.
// Contents rely on block-RAM power-up (all zero); reset does not touch them.
// Out-of-range accesses: writes are dropped, reads return 0.
//
// Ports
//   clk      in  : clock
//   i_we     in  : write enable
//   i_waddr  in  : write address
//   i_wdata  in  : write data
//   i_raddr  in  : read address
//   o_rdata  out : mem[i_raddr] registered on the clock edge
// ---------------------------------------------------------------------------
module eq_coeff_ram #(
    parameter int DEPTH  = 160,
    parameter int DATA_W = 32,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (int'(i_raddr) < DEPTH) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/eq_coeff_ctrl.sv
// ---------------------------------------------------------------------------
// eq_coeff_ctrl
// Double-buffered coefficient store for the equalizer biquads. The equalizer
// reads the active bank while the host fills the shadow bank. A commit swaps
// the banks only at a sample boundary (equalizer idle and no sample being
// accepted), then the new active bank is copied back into the shadow bank so
// later host updates can be sparse.
//
// Ports
//   clk            in  : clock
//   rst_n          in  : asynchronous active-low reset
//   s_cf_d         in  : host coefficient data
//   s_cf_addr      in  : host shadow address (ch*bands*5 + band*5 + k)
//   s_cf_dv        in  : host write valid
//   s_cf_dr        out : host write ready (rst_n and IDLE)
//   cf_commit      in  : request to make the shadow bank active
//   cf_pending     out : commit accepted and copy-back not yet finished
//   cf_bank        out : index of the active bank
//   cf_addr_error  out : one-cycle pulse after an out-of-range host write
//   eq_coeff_addr  in  : equalizer read address
//   eq_coeff       out : active[eq_coeff_addr], one cycle latency
//   eq_idle        in  : equalizer ready (s_eq_dr)
//   eq_start       in  : equalizer accepts a sample this cycle
// ---------------------------------------------------------------------------
module eq_coeff_ctrl
    import eq_pkg::*;
#(
    parameter int NR_CHANNELS    = 4,
    parameter int NR_EQ_BANDS    = 8,
    parameter int EQ_COEFF_WIDTH = 32,
    localparam int NR_EQ_COEFF   = nr_eq_coeff(NR_CHANNELS, NR_EQ_BANDS),
    localparam int AW            = clog2(NR_EQ_COEFF)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [EQ_COEFF_WIDTH-1:0] s_cf_d,
    input  logic [AW-1:0]             s_cf_addr,
    input  logic                      s_cf_dv,
    output logic                      s_cf_dr,
    input  logic                      cf_commit,
    output logic                      cf_pending,
    output logic                      cf_bank,
    output logic                      cf_addr_error,
    input  logic [AW-1:0]             eq_coeff_addr,
    output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
    input  logic                      eq_idle,
    input  logic                      eq_start
);

    localparam logic [AW:0]   LP_NR_COEFF = (AW+1)'(NR_EQ_COEFF);
    localparam logic [AW-1:0] LP_LAST     = AW'(NR_EQ_COEFF - 1);

    cf_state_t r_state;
    cf_state_t w_state_nxt;

    logic                      r_bank;
    logic [AW:0]               r_cnt;
    logic                      r_commit_lat;
    logic                      r_cp_vld_p1;
    logic [AW-1:0]             r_cp_addr_p1;
    logic                      r_addr_err;
    logic                      r_rd_ok_p1;

    logic                      w_dr;
    logic                      w_host_in_range;
    logic                      w_eq_free;
    logic                      w_swap;
    logic                      w_lend;
    logic                      w_copy_last;
    logic                      w_sh_we;
    logic [AW-1:0]             w_sh_addr;
    logic [EQ_COEFF_WIDTH-1:0] w_sh_data;
    logic                      w_we0;
    logic                      w_we1;
    logic [AW-1:0]             w_ra0;
    logic [AW-1:0]             w_ra1;
    logic [EQ_COEFF_WIDTH-1:0] w_rd0;
    logic [EQ_COEFF_WIDTH-1:0] w_rd1;
    logic [EQ_COEFF_WIDTH-1:0] w_act_rd;

    assign w_dr            = rst_n & (r_state == ST_IDLE);
    assign w_host_in_range = ({1'b0, s_cf_addr} < LP_NR_COEFF);
    // Sample boundary: equalizer idle and not taking a sample this cycle.
    assign w_eq_free       = eq_idle & ~eq_start;
    assign w_swap          = (r_state == ST_PEND) & w_eq_free;
    // The active bank's read port goes to the copier only at sample boundaries.
    assign w_lend          = (r_state == ST_COPY) & w_eq_free & (r_cnt < LP_NR_COEFF);
    assign w_copy_last     = r_cp_vld_p1 & (r_cp_addr_p1 == LP_LAST);
    assign w_act_rd        = r_bank ? w_rd1 : w_rd0;

    // Shadow write port: delayed copier write has priority; the host can
    // only write in IDLE, so the two never collide.
    always_comb begin
        w_sh_we   = 1'b0;
        w_sh_addr = s_cf_addr;
        w_sh_data = s_cf_d;
        if (r_cp_vld_p1) begin
            w_sh_we   = 1'b1;
            w_sh_addr = r_cp_addr_p1;
            w_sh_data = w_act_rd;
        end else if (s_cf_dv && w_dr && w_host_in_range) begin
            w_sh_we   = 1'b1;
        end
    end

    // Bank 0 is the shadow when bank 1 is active, and vice versa.
    assign w_we0 = w_sh_we & r_bank;
    assign w_we1 = w_sh_we & ~r_bank;
    assign w_ra0 = (w_lend && !r_bank) ? r_cnt[AW-1:0] : eq_coeff_addr;
    assign w_ra1 = (w_lend &&  r_bank) ? r_cnt[AW-1:0] : eq_coeff_addr;

    eq_coeff_ram #(
        .DEPTH  (NR_EQ_COEFF),
        .DATA_W (EQ_COEFF_WIDTH),
        .AW     (AW)
    ) u_bank0 (
        .clk     (clk),
        .i_we    (w_we0),
        .i_waddr (w_sh_addr),
        .i_wdata (w_sh_data),
        .i_raddr (w_ra0),
        .o_rdata (w_rd0)
    );

    eq_coeff_ram #(
        .DEPTH  (NR_EQ_COEFF),
        .DATA_W (EQ_COEFF_WIDTH),
        .AW     (AW)
    ) u_bank1 (
        .clk     (clk),
        .i_we    (w_we1),
        .i_waddr (w_sh_addr),
        .i_wdata (w_sh_data),
        .i_raddr (w_ra1),
        .o_rdata (w_rd1)
    );

    // A commit seen during COPY (latched or arriving on the last write)
    // sends the block straight back to PEND.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cf_commit) w_state_nxt = ST_PEND;
            ST_PEND: if (w_eq_free) w_state_nxt = ST_COPY;
            ST_COPY: begin
                if (w_copy_last) begin
                    w_state_nxt = (r_commit_lat || cf_commit) ? ST_PEND : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0 -> p1: control state, copy counter, delayed copy valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bank       <= 1'b0;
            r_cnt        <= '0;
            r_commit_lat <= 1'b0;
            r_cp_vld_p1  <= 1'b0;
            r_addr_err   <= 1'b0;
            r_rd_ok_p1   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_err  <= s_cf_dv & w_dr & ~w_host_in_range;
            r_cp_vld_p1 <= w_lend;
            // Copier reads leave the equalizer output at 0 for that cycle.
            r_rd_ok_p1  <= ~w_lend;
            if (w_swap) begin
                r_bank <= ~r_bank;
                r_cnt  <= '0;
            end else if (w_lend) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state != ST_COPY) || w_copy_last) begin
                r_commit_lat <= 1'b0;
            end else if (cf_commit) begin
                r_commit_lat <= 1'b1;
            end
        end
    end

    // Stage p0 -> p1: copy address travels with r_cp_vld_p1
    always_ff @(posedge clk) begin
        r_cp_addr_p1 <= r_cnt[AW-1:0];
    end

    assign s_cf_dr       = w_dr;
    assign cf_pending    = (r_state != ST_IDLE);
    assign cf_bank       = r_bank;
    assign cf_addr_error = r_addr_err;
    assign eq_coeff      = r_rd_ok_p1 ? w_act_rd : '0;

endmodule

// File: tb/tb_eq_coeff_ctrl.sv
module tb_eq_coeff_ctrl;

    localparam int N  = 160;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_cf_d;
    logic [AW-1:0] s_cf_addr;
    logic        s_cf_dv;
    logic        s_cf_dr;
    logic        cf_commit;
    logic        cf_pending;
    logic        cf_bank;
    logic        cf_addr_error;
    logic [AW-1:0] eq_coeff_addr;
    logic [31:0] eq_coeff;
    logic        eq_idle;
    logic        eq_start;

    int errors = 0;
    int checks = 0;

    // Reference model: two physical banks plus the active index.
    logic [31:0] m_bank [2][N];
    int          m_b;

    eq_coeff_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_cf_d        (s_cf_d),
        .s_cf_addr     (s_cf_addr),
        .s_cf_dv       (s_cf_dv),
        .s_cf_dr       (s_cf_dr),
        .cf_commit     (cf_commit),
        .cf_pending    (cf_pending),
        .cf_bank       (cf_bank),
        .cf_addr_error (cf_addr_error),
        .eq_coeff_addr (eq_coeff_addr),
        .eq_coeff      (eq_coeff),
        .eq_idle       (eq_idle),
        .eq_start      (eq_start)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_rd(input int a);
        return (a < N) ? m_bank[m_b][a] : 32'h0;
    endfunction

    task automatic m_write(input int a, input logic [31:0] d);
        if (a < N) m_bank[m_b ^ 1][a] = d;
    endtask

    task automatic m_copy();
        for (int i = 0; i < N; i++) m_bank[m_b ^ 1][i] = m_bank[m_b][i];
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        s_cf_addr = AW'(a);
        s_cf_d    = d;
        s_cf_dv   = 1'b1;
        tick();
        s_cf_dv   = 1'b0;
        m_write(a, d);
        chk($sformatf("addr_err[%0d]", a), 32'(cf_addr_error), 32'(a >= N));
    endtask

    task automatic read_chk(input int a);
        eq_coeff_addr = AW'(a);
        tick();
        chk($sformatf("rd[%0d]", a), eq_coeff, m_rd(a));
    endtask

    initial begin
        int n;
        int n_bank;
        int n_fall;
        int exp_n;
        int on_cnt;
        logic [31:0] v;

        rst_n = 1'b0; s_cf_d = '0; s_cf_addr = '0; s_cf_dv = 1'b0;
        cf_commit = 1'b0; eq_coeff_addr = '0; eq_idle = 1'b1; eq_start = 1'b0;
        m_b = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) m_bank[b][i] = 32'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_dr", 32'(s_cf_dr), 32'd0);
        chk("rst_bank", 32'(cf_bank), 32'd0);
        chk("rst_pending", 32'(cf_pending), 32'd0);
        chk("rst_coeff", eq_coeff, 32'h0);
        chk("rst_addr_err", 32'(cf_addr_error), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_dr", 32'(s_cf_dr), 32'd1);
        chk("rel_pending", 32'(cf_pending), 32'd0);

        // Fill the whole shadow bank with random data, addr 5 fixed
        for (int a = 0; a < N; a++) begin
            v = (a == 5) ? 32'h1000_0000 : $urandom;
            host_write(a, v);
        end

        // Basic swap with the equalizer idle
        eq_coeff_addr = AW'(5);
        cf_commit = 1'b1;
        tick();
        cf_commit = 1'b0;
        chk("commit_pending", 32'(cf_pending), 32'd1);
        chk("commit_bank", 32'(cf_bank), 32'd0);
        chk("commit_dr", 32'(s_cf_dr), 32'd0);
        tick();
        m_b ^= 1;
        chk("swap_bank", 32'(cf_bank), 32'd1);
        chk("swap_rd5", eq_coeff, m_rd(5));
        n = 0;
        while (cf_pending && n < 1000) begin
            tick();
            n++;
        end
        m_copy();
        chk("copy_len", 32'(n), 32'd161);
        chk("copy_dr", 32'(s_cf_dr), 32'd1);
        read_chk(5);
        read_chk(0);
        read_chk(N - 1);
        repeat (10) read_chk($urandom_range(0, N - 1));
        read_chk(200);
        read_chk(255);

        // Out-of-range host writes
        host_write(N, $urandom);
        tick();
        chk("addr_err_pulse", 32'(cf_addr_error), 32'd0);
        host_write(255, $urandom);

        // Deferred swap: equalizer busy for 50 cycles
        host_write(9, $urandom);
        eq_idle = 1'b0;
        eq_coeff_addr = AW'(9);
        cf_commit = 1'b1;
        tick();
        cf_commit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cf_commit = (i == 20);
            tick();
        end
        cf_commit = 1'b0;
        chk("defer_bank", 32'(cf_bank), 32'd1);
        chk("defer_pending", 32'(cf_pending), 32'd1);
        chk("defer_rd9", eq_coeff, m_rd(9));
        eq_coeff_addr = AW'(5);
        tick();
        chk("defer_rd5", eq_coeff, m_rd(5));
        eq_idle = 1'b1;
        eq_start = 1'b1;
        tick();
        chk("defer_start_bank", 32'(cf_bank), 32'd1);
        eq_start = 1'b0;
        eq_coeff_addr = AW'(9);
        tick();
        m_b ^= 1;
        chk("defer_swap_bank", 32'(cf_bank), 32'd0);
        chk("defer_swap_rd9", eq_coeff, m_rd(9));

        // Copy with the equalizer idle 3 cycles of every 8
        on_cnt = 0;
        exp_n = -1;
        for (int j = 0; j < 2000 && exp_n < 0; j++) begin
            if ((j % 8) < 3) begin
                on_cnt++;
                if (on_cnt == N) exp_n = j + 2;
            end
        end
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            eq_idle = ((i % 8) < 3);
            tick();
            if (!cf_pending) begin
                n = i + 1;
                break;
            end
        end
        eq_idle = 1'b1;
        m_copy();
        chk("stall_len", 32'(n), 32'(exp_n));

        // Sparse update, one write together with the commit
        host_write(7, 32'h2);
        v = $urandom;
        s_cf_addr = AW'(11);
        s_cf_d = v;
        s_cf_dv = 1'b1;
        cf_commit = 1'b1;
        eq_coeff_addr = AW'(11);
        tick();
        m_write(11, v);
        s_cf_dv = 1'b0;
        cf_commit = 1'b0;
        tick();
        m_b ^= 1;
        chk("sparse_bank", 32'(cf_bank), 32'd1);
        chk("sparse_rd11", eq_coeff, m_rd(11));

        // Commit during COPY: second swap follows at copy end
        n_bank = 0;
        n_fall = 0;
        for (int k = 1; k <= 1000; k++) begin
            cf_commit = (k == 10);
            tick();
            if (k == 161) begin
                chk("recommit_pending", 32'(cf_pending), 32'd1);
                chk("recommit_bank_hold", 32'(cf_bank), 32'd1);
            end
            if (n_bank == 0 && cf_bank == 1'b0) n_bank = k;
            if (!cf_pending) begin
                n_fall = k;
                break;
            end
        end
        cf_commit = 1'b0;
        m_copy();
        m_b ^= 1;
        m_copy();
        chk("recommit_swap_at", 32'(n_bank), 32'd162);
        chk("recommit_fall_at", 32'(n_fall), 32'd323);
        read_chk(5);
        read_chk(7);
        for (int a = 0; a < N; a++) read_chk(a);

        // Reset in the middle of COPY
        cf_commit = 1'b1;
        tick();
        cf_commit = 1'b0;
        tick();
        chk("pre_rst_bank", 32'(cf_bank), 32'd1);
        repeat (20) tick();
        chk("pre_rst_pending", 32'(cf_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dr", 32'(s_cf_dr), 32'd0);
        chk("midrst_bank", 32'(cf_bank), 32'd0);
        chk("midrst_pending", 32'(cf_pending), 32'd0);
        chk("midrst_coeff", eq_coeff, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_dr", 32'(s_cf_dr), 32'd1);
        chk("postrst_bank", 32'(cf_bank), 32'd0);
        chk("postrst_pending", 32'(cf_pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
